msk_frame_sync: RTL and testbench

- Sits directly downstream of the MSK differential slicer/decoder. Consumes its hard-bit stream (one bit per bit_valid_i pulse).
- Hunts for a 32-bit sync word, tolerating a programmable number of bit errors.
- After a sync hit, reads an 8-bit length header and emits that many payload bytes with start-of-frame and end-of-frame markers.
- Feeds the byte-level packet sink or FIFO.

---
 rtl/msk_frame_sync.sv | 166 ++++++++++++++++
 tb/tb_msk_frame_sync.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/msk_frame_sync.sv
// MSK frame synchroniser: hunts for an error-tolerant sync word in the hard-bit
// stream, then emits a length-prefixed payload as bytes with SOF/EOF markers.
module msk_frame_sync #(
  parameter int                SW        = 32,
  parameter logic [SW-1:0]     SYNC_WORD = 32'h1ACFFC1D,
  parameter int                MAX_ERR   = 2,
  localparam int               EW        = $clog2(SW + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          bit_i,
  input  logic          bit_valid_i,
  output logic [7:0]    byte_o,
  output logic          byte_valid_o,
  output logic          sof_o,
  output logic          eof_o,
  output logic          sync_det_o,
  output logic [EW-1:0] sync_errs_o,
  output logic          len_err_o,
  output logic          locked_o
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  localparam logic [EW-1:0] SW_W   = EW'(SW);
  localparam logic [EW-1:0] MAXE_W = EW'(MAX_ERR);

  state_t        r_state, w_state_n;
  logic [SW-1:0] r_sreg, w_sreg_n;
  logic [EW-1:0] r_fill, w_fill_n;
  logic [2:0]    r_bitcnt, w_bitcnt_n;
  logic [7:0]    r_bytecnt, w_bytecnt_n;
  logic [7:0]    r_len, w_len_n;
  logic [7:0]    r_byte, w_byte_n;
  logic [EW-1:0] r_errs, w_errs_n;
  logic          r_byte_vld, w_byte_vld_n;
  logic          r_sof, w_sof_n;
  logic          r_eof, w_eof_n;
  logic          r_sync_det, w_sync_det_n;
  logic          r_len_err, w_len_err_n;

  logic [SW-1:0] w_shift;
  logic [EW-1:0] w_fill_inc;
  logic [EW-1:0] w_dist;

  function automatic logic [EW-1:0] popcount(input logic [SW-1:0] v);
    logic [EW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < SW; i++) c = c + EW'(v[i]);
    return c;
  endfunction

  // Distance is taken on the shifted-in value so the hit is seen on the last sync bit.
  assign w_shift    = {r_sreg[SW-2:0], bit_i};
  assign w_fill_inc = (r_fill == SW_W) ? SW_W : r_fill + 1'b1;
  assign w_dist     = popcount(w_shift ^ SYNC_WORD);

  always_comb begin
    w_state_n     = r_state;
    w_sreg_n      = r_sreg;
    w_fill_n      = r_fill;
    w_bitcnt_n    = r_bitcnt;
    w_bytecnt_n   = r_bytecnt;
    w_len_n       = r_len;
    w_byte_n      = r_byte;
    w_errs_n      = r_errs;
    w_byte_vld_n  = 1'b0;
    w_sof_n       = 1'b0;
    w_eof_n       = 1'b0;
    w_sync_det_n  = 1'b0;
    w_len_err_n   = 1'b0;
    if (bit_valid_i) begin
      w_sreg_n = w_shift;
      unique case (r_state)
        S_HUNT: begin
          w_fill_n = w_fill_inc;
          if (w_fill_inc == SW_W && w_dist <= MAXE_W) begin
            w_sync_det_n = 1'b1;
            w_errs_n     = w_dist;
            w_bitcnt_n   = '0;
            w_state_n    = S_LEN;
          end
        end
        S_LEN: begin
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_len_n = w_shift[7:0];
            if (w_shift[7:0] == 8'd0) begin
              w_len_err_n = 1'b1;
              w_fill_n    = '0;
              w_state_n   = S_HUNT;
            end else begin
              w_bytecnt_n = '0;
              w_bitcnt_n  = '0;
              w_state_n   = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_byte_vld_n = 1'b1;
            w_byte_n     = w_shift[7:0];
            w_sof_n      = (r_bytecnt == 8'd0);
            w_eof_n      = (r_bytecnt == r_len - 8'd1);
            w_bytecnt_n  = r_bytecnt + 8'd1;
            if (r_bytecnt == r_len - 8'd1) begin
              w_fill_n  = '0;
              w_state_n = S_HUNT;
            end
          end
        end
        default: begin
          w_fill_n  = '0;
          w_state_n = S_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_HUNT;
      r_sreg     <= '0;
      r_fill     <= '0;
      r_bitcnt   <= '0;
      r_bytecnt  <= '0;
      r_len      <= '0;
      r_byte     <= '0;
      r_errs     <= '0;
      r_byte_vld <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_sync_det <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_sreg     <= w_sreg_n;
      r_fill     <= w_fill_n;
      r_bitcnt   <= w_bitcnt_n;
      r_bytecnt  <= w_bytecnt_n;
      r_len      <= w_len_n;
      r_byte     <= w_byte_n;
      r_errs     <= w_errs_n;
      r_byte_vld <= w_byte_vld_n;
      r_sof      <= w_sof_n;
      r_eof      <= w_eof_n;
      r_sync_det <= w_sync_det_n;
      r_len_err  <= w_len_err_n;
    end
  end

  assign byte_o       = r_byte;
  assign byte_valid_o = r_byte_vld;
  assign sof_o        = r_sof;
  assign eof_o        = r_eof;
  assign sync_det_o   = r_sync_det;
  assign sync_errs_o  = r_errs;
  assign len_err_o    = r_len_err;
  assign locked_o     = (r_state != S_HUNT);

endmodule

// File: tb/tb_msk_frame_sync.sv
// Directed frame table for msk_frame_sync: each row is a frame with its expected
// sync/length/byte outcome; a monitor attributes output strobes to table rows.
module tb_msk_frame_sync;

  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bit_i;
  logic       bit_valid_i;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       sof_o;
  logic       eof_o;
  logic       sync_det_o;
  logic [5:0] sync_errs_o;
  logic       len_err_o;
  logic       locked_o;

  msk_frame_sync #(.SW(32), .SYNC_WORD(32'h1ACFFC1D), .MAX_ERR(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bit_i        (bit_i),
    .bit_valid_i  (bit_valid_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .sync_det_o   (sync_det_o),
    .sync_errs_o  (sync_errs_o),
    .len_err_o    (len_err_o),
    .locked_o     (locked_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pre;
    int          gap;
    logic [31:0] sw;
    logic [7:0]  len;
    int          nsend;
    logic [31:0] pay;
    bit          rst;
    int          edet;
    int          eerrs;
    int          elen;
    int          enb;
  } vec_t;

  typedef struct {
    int         row;
    logic [7:0] b;
    logic       sof;
    logic       eof;
    logic       lat;
  } ev_t;

  vec_t tbl[NR];
  ev_t  evq[$];

  // Tag of the bit currently driven: 1 = 8th payload bit, 2 = last sync bit, 3 = last length bit.
  int d_tag = 0;
  int d_row = 0;

  int sync_cnt[NR]  = '{default: 0};
  int sync_bad[NR]  = '{default: 0};
  int errs_seen[NR] = '{default: 0};
  int lerr_cnt[NR]  = '{default: 0};
  int lerr_bad[NR]  = '{default: 0};

  int nchk = 0;
  int nerr = 0;

  always @(posedge clk) begin : mon
    int   s_tag;
    int   s_row;
    logic s_v;
    s_tag = d_tag;
    s_row = d_row;
    s_v   = bit_valid_i;
    #1;
    if (byte_valid_o === 1'b1)
      evq.push_back('{s_row, byte_o, sof_o, eof_o, (s_v && s_tag == 1)});
    if (sync_det_o === 1'b1) begin
      sync_cnt[s_row]  <= sync_cnt[s_row] + 1;
      errs_seen[s_row] <= 32'(sync_errs_o);
      if (!(s_v && s_tag == 2)) sync_bad[s_row] <= sync_bad[s_row] + 1;
    end
    if (len_err_o === 1'b1) begin
      lerr_cnt[s_row] <= lerr_cnt[s_row] + 1;
      if (!(s_v && s_tag == 3)) lerr_bad[s_row] <= lerr_bad[s_row] + 1;
    end
  end

  function automatic vec_t mk(int pre, int gap, logic [31:0] sw, logic [7:0] len,
                              int nsend, logic [31:0] pay, bit rst,
                              int edet, int eerrs, int elen, int enb);
    vec_t v;
    v.pre = pre; v.gap = gap; v.sw = sw; v.len = len; v.nsend = nsend;
    v.pay = pay; v.rst = rst; v.edet = edet; v.eerrs = eerrs; v.elen = elen; v.enb = enb;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  // Starts and returns on a negedge; invalid filler cycles carry the inverted bit.
  task automatic drive_bit(input logic b, input int tag, input int row, input int gap);
    bit_i       = b;
    bit_valid_i = 1'b1;
    d_tag       = tag;
    d_row       = row;
    @(negedge clk);
    for (int j = 1; j < gap; j++) begin
      bit_valid_i = 1'b0;
      bit_i       = ~b;
      d_tag       = 0;
      @(negedge clk);
    end
  endtask

  task automatic send_row(input int r);
    logic [19:0] pre_bits;
    logic [7:0]  pb;
    vec_t        v;
    v        = tbl[r];
    pre_bits = 20'h5A3C9;
    for (int i = 0; i < v.pre; i++) drive_bit(pre_bits[19-i], 0, r, v.gap);
    for (int i = 31; i >= 0; i--) drive_bit(v.sw[i], (i == 0) ? 2 : 0, r, v.gap);
    chk("locked_after_sync", r, 32'(locked_o), 32'(v.edet));
    for (int i = 7; i >= 0; i--) drive_bit(v.len[i], (i == 0) ? 3 : 0, r, v.gap);
    for (int k = 0; k < v.nsend; k++) begin
      pb = 8'(v.pay >> (24 - 8 * k));
      for (int i = 7; i >= 0; i--) drive_bit(pb[i], (i == 0) ? 1 : 0, r, v.gap);
    end
    if (v.rst) begin
      bit_valid_i = 1'b0;
      reset_n     = 1'b0;
      @(negedge clk);
      chk("outputs_after_reset", r,
          32'({byte_o, byte_valid_o, sof_o, eof_o, sync_det_o, sync_errs_o, len_err_o, locked_o}),
          32'd0);
      reset_n = 1'b1;
    end else begin
      chk("locked_at_row_end", r, 32'(locked_o), 32'd0);
    end
  endtask

  initial begin
    int   k;
    vec_t v;
    //            pre gap sync word     len    ns pay           rst det errs lerr nb
    tbl[0] = mk(20, 1, 32'h1ACFFC1D, 8'd3, 3, 32'hA53CFF00, 0, 1, 0, 0, 3);
    tbl[1] = mk(20, 1, 32'h9ACFFC1F, 8'd1, 1, 32'h11000000, 0, 1, 2, 0, 1);
    tbl[2] = mk(20, 1, 32'h9ACEFC1F, 8'd1, 1, 32'h00000000, 0, 0, 0, 0, 0);
    tbl[3] = mk(20, 1, 32'h1ACFFC1D, 8'd0, 0, 32'h00000000, 0, 1, 0, 1, 0);
    tbl[4] = mk( 0, 1, 32'h1ACFFC1D, 8'd1, 1, 32'h42000000, 0, 1, 0, 0, 1);
    tbl[5] = mk(20, 5, 32'h1ACFFC1D, 8'd3, 3, 32'hA53CFF00, 0, 1, 0, 0, 3);
    tbl[6] = mk(20, 1, 32'h1ACFFC1D, 8'd4, 4, 32'h1ACFFC1D, 0, 1, 0, 0, 4);
    tbl[7] = mk( 0, 1, 32'h1ACFFC1D, 8'd1, 1, 32'h99000000, 0, 1, 0, 0, 1);
    tbl[8] = mk(20, 1, 32'h1ACFFC1D, 8'd5, 2, 32'hC3A50000, 1, 1, 0, 0, 2);
    tbl[9] = mk(20, 1, 32'h1ACFFC1D, 8'd2, 2, 32'h5E770000, 0, 1, 0, 0, 2);

    reset_n     = 1'b0;
    bit_i       = 1'b0;
    bit_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 0,
        32'({byte_o, byte_valid_o, sof_o, eof_o, sync_det_o, sync_errs_o, len_err_o, locked_o}),
        32'd0);
    reset_n = 1'b1;

    for (int r = 0; r < NR; r++) send_row(r);
    bit_valid_i = 1'b0;
    repeat (5) @(negedge clk);

    for (int r = 0; r < NR; r++) begin
      v = tbl[r];
      chk("sync_count", r, 32'(sync_cnt[r]), 32'(v.edet));
      if (v.edet > 0 && sync_cnt[r] > 0)
        chk("sync_errs", r, 32'(errs_seen[r]), 32'(v.eerrs));
      chk("sync_latency", r, 32'(sync_bad[r]), 32'd0);
      chk("len_err_count", r, 32'(lerr_cnt[r]), 32'(v.elen));
      chk("len_err_latency", r, 32'(lerr_bad[r]), 32'd0);
      k = 0;
      foreach (evq[i]) begin
        if (evq[i].row == r) begin
          chk("byte_value", r, 32'(evq[i].b), (k < 4) ? 32'(8'(v.pay >> (24 - 8 * k))) : 32'hFFFF_FFFF);
          chk("byte_sof", r, 32'(evq[i].sof), 32'(k == 0));
          chk("byte_eof", r, 32'(evq[i].eof), 32'(k == int'(v.len) - 1));
          chk("byte_latency", r, 32'(evq[i].lat), 32'd1);
          k++;
        end
      end
      chk("byte_count", r, 32'(k), 32'(v.enb));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
